param_sync_fifo: RTL and testbench



---
 rtl/fifo_param_pkg.sv | 24 ++
 rtl/fifo_ram.sv | 28 ++
 rtl/param_sync_fifo.sv | 129 ++++++++++++
 tb/tb_param_sync_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_param_pkg.sv
// Shared defaults, width helpers and read-mode enum for the parametrised FIFO.
package fifo_param_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_DEPTH     = 32;
    localparam int unsigned DEF_AF_THRESH = DEF_DEPTH - 4;
    localparam int unsigned DEF_AE_THRESH = 4;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_t;

    // Pointer width for a power-of-two depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy width: must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
    import fifo_param_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [ptr_w(DEPTH)-1:0]  waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [ptr_w(DEPTH)-1:0]  raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is a plain array lookup so FWFT can present data immediately.
    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with configurable width/depth, thresholds, FWFT option
// and sticky overflow/underflow flags.
module param_sync_fifo
    import fifo_param_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    parameter int unsigned AE_THRESH = DEF_AE_THRESH,
    parameter int unsigned FWFT      = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam fifo_mode_t  MODE = (FWFT != 0) ? fifo_param_pkg::FWFT : fifo_param_pkg::STD;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    ptr_t              wptr;
    ptr_t              rptr;
    cnt_t              cnt;
    logic              push_c;
    logic              pop_c;
    logic [DATA_W-1:0] ram_rdata;

    // Flags decode the registered occupancy.
    assign empty        = (cnt == '0);
    assign full         = (cnt == CW'(DEPTH));
    assign almost_full  = (cnt >= CW'(AF_THRESH));
    assign almost_empty = (cnt <= CW'(AE_THRESH));
    assign count        = cnt;

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign pop_c  = rd_en && !empty;
    assign push_c = wr_en && (!full || pop_c);

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .CLK    (CLK),
        .we     (push_c),
        .waddr  (wptr),
        .wdata  (wr_data),
        .raddr  (rptr),
        .rdata  (ram_rdata)
    );

    // Pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_c) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_c) begin
                rptr <= rptr + AW'(1);
            end
            if (push_c && !pop_c) begin
                cnt <= cnt + CW'(1);
            end else if (pop_c && !push_c) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Sticky error flags; clearing wins over a coincident new error.
    always_ff @(posedge CLK) begin
        if (RST || clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !push_c) begin
                overflow <= 1'b1;
            end
            if (rd_en && !pop_c) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (MODE == fifo_param_pkg::FWFT) begin : g_fwft
            // Head word is presented as soon as it is stored.
            assign rd_data  = ram_rdata;
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            // Registered read stage: data one cycle after the pop, held otherwise.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= pop_c;
                    if (pop_c) begin
                        rd_data_q <= ram_rdata;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO share stimulus
// and are compared every cycle against a queue-based model.
module tb_param_sync_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AF    = DEPTH - 4;
    localparam int unsigned AE    = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae;
    logic [CW-1:0] s_count, f_count;
    logic          s_ovf, f_ovf, s_udf, f_udf;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    bit            m_sv  = 1'b0;
    logic [DW-1:0] m_sd  = '0;

    always #5 CLK = ~CLK;

    param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
    );

    param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each edge, then compare both DUTs shortly after.
    always @(posedge CLK) begin
        int   n;
        bit   pop, push;
        logic [DW-1:0] head;
        if (RST) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_sv  = 1'b0;
            m_sd  = '0;
        end else begin
            n    = mq.size();
            pop  = rd_en && (n != 0);
            push = wr_en && ((n < DEPTH) || pop);
            m_sv = pop;
            if (pop) begin
                head = mq.pop_front();
                m_sd = head;
            end
            if (push) mq.push_back(wr_data);
            if (clr_err) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (wr_en && !push) m_ovf = 1'b1;
                if (rd_en && !pop)  m_udf = 1'b1;
            end
        end
        #1;
        n = mq.size();
        chk("std_count", 64'(s_count), 64'(n));
        chk("fwft_count", 64'(f_count), 64'(n));
        chk("std_empty", 64'(s_empty), 64'(n == 0));
        chk("fwft_empty", 64'(f_empty), 64'(n == 0));
        chk("std_full", 64'(s_full), 64'(n == DEPTH));
        chk("std_almost_full", 64'(s_af), 64'(n >= AF));
        chk("std_almost_empty", 64'(s_ae), 64'(n <= AE));
        chk("fwft_almost_full", 64'(f_af), 64'(n >= AF));
        chk("std_overflow", 64'(s_ovf), 64'(m_ovf));
        chk("std_underflow", 64'(s_udf), 64'(m_udf));
        chk("fwft_overflow", 64'(f_ovf), 64'(m_ovf));
        chk("fwft_underflow", 64'(f_udf), 64'(m_udf));
        chk("std_rd_valid", 64'(s_rd_valid), 64'(m_sv));
        chk("std_rd_data", 64'(s_rd_data), 64'(m_sd));
        chk("fwft_rd_valid", 64'(f_rd_valid), 64'(n != 0));
        if (n != 0) chk("fwft_rd_data", 64'(f_rd_data), 64'(mq[0]));
    end

    // One stimulus cycle: inputs change on the falling edge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input bit rs);
        @(negedge CLK);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        RST     = rs;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pw;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("lit_reset_empty", 64'(s_empty), 64'd1);
        chk("lit_reset_count", 64'(s_count), 64'd0);
        chk("lit_reset_ae", 64'(s_ae), 64'd1);

        // Two writes, two pops
        cyc(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_t1_count2", 64'(s_count), 64'd2);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("lit_t1_rd_data", 64'(s_rd_data), 64'h2);
        chk("lit_t1_rd_valid", 64'(s_rd_valid), 64'd1);
        chk("lit_t1_empty", 64'(s_empty), 64'd1);

        // Overfill with 37 writes
        for (int i = 1; i <= 37; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_t2_count", 64'(s_count), 64'd32);
        chk("lit_t2_full", 64'(s_full), 64'd1);
        chk("lit_t2_overflow", 64'(s_ovf), 64'd1);
        chk("lit_t2_model", 64'(mq.size()), 64'd32);

        // Over-drain with 40 reads, then clear errors
        for (int i = 0; i < 40; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("lit_t3_last_data", 64'(s_rd_data), 64'd32);
        chk("lit_t3_underflow", 64'(s_udf), 64'd1);
        chk("lit_t3_empty", 64'(s_empty), 64'd1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("lit_t3_ovf_clr", 64'(s_ovf), 64'd0);
        chk("lit_t3_udf_clr", 64'(s_udf), 64'd0);

        // Simultaneous read/write at count 5, 32 and 0
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, DW'(200 + i), 1'b1, 1'b0, 1'b0);
        idle();
        chk("lit_t4_count5", 64'(s_count), 64'd5);
        chk("lit_t4_head", 64'(f_rd_data), 64'd104);
        for (int i = 0; i < 27; i++) cyc(1'b1, DW'(300 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, DW'(400 + i), 1'b1, 1'b0, 1'b0);
        idle();
        chk("lit_t4_count32", 64'(s_count), 64'd32);
        chk("lit_t4_no_ovf", 64'(s_ovf), 64'd0);
        for (int i = 0; i < 32; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
        idle();
        chk("lit_t4_udf", 64'(s_udf), 64'd1);
        chk("lit_t4_count1", 64'(s_count), 64'd1);
        chk("lit_t4_fwft_head", 64'(f_rd_data), 64'h77);

        // Reset mid-operation with a write pending
        for (int i = 0; i < 9; i++) cyc(1'b1, DW'(500 + i), 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_t6_count10", 64'(s_count), 64'd10);
        cyc(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1);
        idle();
        chk("lit_t6_count0", 64'(s_count), 64'd0);
        chk("lit_t6_empty", 64'(s_empty), 64'd1);
        chk("lit_t6_rd_valid", 64'(s_rd_valid), 64'd0);
        chk("lit_t6_udf", 64'(s_udf), 64'd0);

        // FWFT presentation without rd_en
        cyc(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_t5_valid", 64'(f_rd_valid), 64'd1);
        chk("lit_t5_data", 64'(f_rd_data), 64'hA5);
        chk("lit_t5_not_empty", 64'(f_empty), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("lit_t5_empty", 64'(f_empty), 64'd1);
        chk("lit_t5_std_data", 64'(s_rd_data), 64'hA5);

        // Randomised traffic with phases biased towards full, balanced, empty
        for (int i = 0; i < 3000; i++) begin
            case ((i / 200) % 3)
                0:       pw = 80;
                1:       pw = 50;
                default: pw = 20;
            endcase
            cyc(($urandom_range(99) < 32'(pw)), DW'($urandom),
                ($urandom_range(99) >= 32'(pw)),
                ($urandom_range(49) == 0),
                ($urandom_range(999) == 0));
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
